// File: rtl/wb_pipeline_unit_if.sv
// ---------------------------------------------------------------------------
// wb_pipeline_unit_if
// Bundles the MEM->WB instruction bus, the register-file write port, the
// EX-stage forwarding query and the retire counter for wb_pipeline_unit.
//
// Modports:
//   master : MEM-stage / EX-stage side. Drives the i_* signals and observes
//            the o_* signals.
//   slave  : writeback stage. Observes the i_* signals and drives the o_*
//            signals.
//
// Signal groups:
//   control   : i_valid, i_stall, i_flush
//   datapath  : i_ALU_rslt, i_data, i_pc, i_addr_lo
//   load ctl  : i_ld_size, i_ld_unsigned
//   routing   : i_flg_wb_src, i_flg_ALU_dst, i_rd, i_rt, i_flg_reg_wr
//   fwd query : i_chk_rs, i_chk_rt -> o_fwd_rs, o_fwd_rt
//   reg write : o_wr_data, o_reg_sel, o_reg_wr, o_valid
//   counter   : o_retired
// ---------------------------------------------------------------------------
interface wb_pipeline_unit_if #(
    parameter int NBITS   = 32,
    parameter int NREGSEL = 5
) ();
    logic               i_valid;
    logic               i_stall;
    logic               i_flush;
    logic [NBITS-1:0]   i_ALU_rslt;
    logic [NBITS-1:0]   i_data;
    logic [NBITS-1:0]   i_pc;
    logic [1:0]         i_addr_lo;
    logic [1:0]         i_ld_size;
    logic               i_ld_unsigned;
    logic [1:0]         i_flg_wb_src;
    logic [1:0]         i_flg_ALU_dst;
    logic [NREGSEL-1:0] i_rd;
    logic [NREGSEL-1:0] i_rt;
    logic               i_flg_reg_wr;
    logic [NREGSEL-1:0] i_chk_rs;
    logic [NREGSEL-1:0] i_chk_rt;

    logic [NBITS-1:0]   o_wr_data;
    logic [NREGSEL-1:0] o_reg_sel;
    logic               o_reg_wr;
    logic               o_valid;
    logic               o_fwd_rs;
    logic               o_fwd_rt;
    logic [31:0]        o_retired;

    modport master (
        output i_valid, i_stall, i_flush, i_ALU_rslt, i_data, i_pc,
               i_addr_lo, i_ld_size, i_ld_unsigned, i_flg_wb_src,
               i_flg_ALU_dst, i_rd, i_rt, i_flg_reg_wr, i_chk_rs, i_chk_rt,
        input  o_wr_data, o_reg_sel, o_reg_wr, o_valid, o_fwd_rs, o_fwd_rt,
               o_retired
    );

    modport slave (
        input  i_valid, i_stall, i_flush, i_ALU_rslt, i_data, i_pc,
               i_addr_lo, i_ld_size, i_ld_unsigned, i_flg_wb_src,
               i_flg_ALU_dst, i_rd, i_rt, i_flg_reg_wr, i_chk_rs, i_chk_rt,
        output o_wr_data, o_reg_sel, o_reg_wr, o_valid, o_fwd_rs, o_fwd_rt,
               o_retired
    );
endinterface

// File: rtl/wb_pipeline_unit.sv
// ---------------------------------------------------------------------------
// wb_pipeline_unit
// Registered MIPS writeback stage. Holds the MEM/WB pipeline register,
// performs load byte/halfword extraction with sign/zero extension, selects
// the writeback source (memory, ALU, PC+8 link), picks the destination
// register, and drives the register-file write port. It also flags EX-stage
// source operands that match the pending writeback.
//
// Ports:
//   i_clk : clock, all state updates on the rising edge
//   i_rst : synchronous active-high reset
//   bus   : wb_pipeline_unit_if.slave (see the interface file for signals)
//
// Optional feature macro: WB_RETIRE_CNT_EN
//   defined   : 32-bit retired-instruction counter on bus.o_retired
//   undefined : bus.o_retired tied to 0, no counter built
// ---------------------------------------------------------------------------
module wb_pipeline_unit #(
    parameter int NBITS    = 32,
    parameter int NREGSEL  = 5,
    parameter int LINK_REG = 31
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    wb_pipeline_unit_if.slave      bus
);

    // ---------------------------------------------------------------
    // Load extraction (combinational, ahead of the pipeline register)
    // ---------------------------------------------------------------
    logic [7:0]       byte_lane [4];
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [NBITS-1:0] word_ext;
    logic [NBITS-1:0] load_ext;
    logic [NBITS-1:0] link_data;
    logic             sign_en;

    // Little-endian byte lanes of the low 32 bits of the memory word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lane[gi] = bus.i_data[8*gi +: 8];
        end
    endgenerate

    assign sign_en = ~bus.i_ld_unsigned;

    // Word loads only need extension when the datapath is wider than 32.
    generate
        if (NBITS > 32) begin : g_word_wide
            assign word_ext = {{(NBITS-32){sign_en & bus.i_data[31]}},
                               bus.i_data[31:0]};
        end else begin : g_word_native
            assign word_ext = bus.i_data[31:0];
        end
    endgenerate

    // PC+8 wraps modulo 2^NBITS by plain truncation.
    assign link_data = bus.i_pc + NBITS'(8);

    always_comb begin
        byte_sel = byte_lane[bus.i_addr_lo];
        // Halfword misalignment (addr_lo[0]=1) is not trapped; bit 0 ignored.
        half_sel = bus.i_addr_lo[1] ? bus.i_data[31:16] : bus.i_data[15:0];
        case (bus.i_ld_size)
            2'b00:   load_ext = {{(NBITS-8){sign_en & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{(NBITS-16){sign_en & half_sel[15]}}, half_sel};
            default: load_ext = word_ext;
        endcase
    end

    // ---------------------------------------------------------------
    // Source / destination selection and next-state
    // ---------------------------------------------------------------
    logic               accept;
    logic               valid_reg,   valid_next;
    logic [NBITS-1:0]   wr_data_reg, wr_data_next;
    logic [NREGSEL-1:0] reg_sel_reg, reg_sel_next;
    logic               reg_wr_reg,  reg_wr_next;

    // Flush and stall both produce a bubble; flush's priority over stall
    // only matters in that either one blocks capture.
    assign accept = bus.i_valid & ~bus.i_flush & ~bus.i_stall;

    always_comb begin
        valid_next   = accept;
        wr_data_next = wr_data_reg;
        reg_sel_next = reg_sel_reg;
        reg_wr_next  = reg_wr_reg;
        if (accept) begin
            case (bus.i_flg_wb_src)
                2'b00:   wr_data_next = load_ext;
                2'b10:   wr_data_next = link_data;
                default: wr_data_next = bus.i_ALU_rslt;
            endcase
            case (bus.i_flg_ALU_dst)
                2'b00:   reg_sel_next = bus.i_rt;
                2'b01:   reg_sel_next = bus.i_rd;
                2'b10:   reg_sel_next = '0;
                default: reg_sel_next = NREGSEL'(LINK_REG);
            endcase
            reg_wr_next = bus.i_flg_reg_wr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_reg   <= 1'b0;
            wr_data_reg <= '0;
            reg_sel_reg <= '0;
            reg_wr_reg  <= 1'b0;
        end else begin
            valid_reg   <= valid_next;
            wr_data_reg <= wr_data_next;
            reg_sel_reg <= reg_sel_next;
            reg_wr_reg  <= reg_wr_next;
        end
    end

    // ---------------------------------------------------------------
    // Register-file write port and forwarding flags
    // ---------------------------------------------------------------
    logic wr_en;

    // valid_reg drops on every bubble, so a stalled instruction never
    // writes twice; r0 writes are suppressed here for every source.
    assign wr_en = valid_reg & reg_wr_reg & (reg_sel_reg != '0);

    assign bus.o_wr_data = wr_data_reg;
    assign bus.o_reg_sel = reg_sel_reg;
    assign bus.o_reg_wr  = wr_en;
    assign bus.o_valid   = valid_reg;

    // wr_en already excludes r0, so an index-0 query can never match.
    assign bus.o_fwd_rs = wr_en & (reg_sel_reg == bus.i_chk_rs);
    assign bus.o_fwd_rt = wr_en & (reg_sel_reg == bus.i_chk_rt);

    // ---------------------------------------------------------------
    // Retired-instruction counter
    // ---------------------------------------------------------------
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retired_reg;

    // Counts every instruction that leaves WB, including r0 targets and
    // non-writing instructions; wraps naturally at 2^32.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            retired_reg <= '0;
        end else if (valid_reg) begin
            retired_reg <= retired_reg + 32'd1;
        end
    end

    assign bus.o_retired = retired_reg;
`else
    assign bus.o_retired = '0;
`endif

endmodule
